// File: rtl/seg7_axis_decoder.sv
// Seven-segment two-digit AXI-Stream decoder with output FIFO.
// s_* : sink of {tens,ones} segment codes; m_* : decoded value + error flag.
//
// Ports:
//   clk, rstn           clock (rising edge), async active-low reset
//   s_valid/s_ready     input handshake
//   s_data[1:0][6:0]    [1]=tens, [0]=ones, bit order {g,f,e,d,c,b,a}
//   m_valid/m_ready     output handshake
//   m_data[W_OUT-1:0]   decoded tens*10+ones (FIFO head)
//   m_err               head beat held an invalid code
//   err_count[ERR_W-1:0] saturating count of accepted bad beats
//   clr_err             synchronous clear of err_count
module seg7_axis_decoder #(
    parameter int W_OUT = 7,
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [1:0][6:0]  s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W_OUT-1:0] m_data,
    output logic             m_err,
    output logic [ERR_W-1:0] err_count,
    input  logic             clr_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    // Returns {invalid, digit}; invalid codes decode as digit 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] code);
        case (code)
            7'h3F:   return 5'd0;
            7'h06:   return 5'd1;
            7'h5B:   return 5'd2;
            7'h4F:   return 5'd3;
            7'h66:   return 5'd4;
            7'h6D:   return 5'd5;
            7'h7D:   return 5'd6;
            7'h07:   return 5'd7;
            7'h7F:   return 5'd8;
            7'h6F:   return 5'd9;
            default: return 5'h10;
        endcase
    endfunction

    logic [4:0]       dec_tens;
    logic [4:0]       dec_ones;
    logic             dec_err;
    logic             accept;
    logic             push;
    logic             pop;
    logic             ready_en;
    logic             st_valid;
    logic [3:0]       st_tens;
    logic [3:0]       st_ones;
    logic             st_err;
    logic [6:0]       st_sum;
    logic [W_OUT:0]   push_word;
    logic [W_OUT:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    fifo_count;

    assign dec_tens = seg_decode(s_data[1]);
    assign dec_ones = seg_decode(s_data[0]);
    assign dec_err  = dec_tens[4] | dec_ones[4];

    // Counting the staged beat reserves its FIFO slot, so the push one
    // cycle later can never hit a full FIFO.
    assign s_ready = ready_en &&
                     ((fifo_count + CW'(st_valid)) < CW'(DEPTH));
    assign accept  = s_valid && s_ready;
    assign push    = st_valid;
    assign pop     = m_valid && m_ready;

    assign st_sum    = ({3'b000, st_tens} * 7'd10) + {3'b000, st_ones};
    assign push_word = {st_err, W_OUT'(st_sum)};

    assign m_valid = (fifo_count != '0);
    assign m_data  = mem[rd_ptr][W_OUT-1:0];
    assign m_err   = mem[rd_ptr][W_OUT];

    // Holds s_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ready_en <= 1'b0;
        else       ready_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_valid <= 1'b0;
            st_tens  <= '0;
            st_ones  <= '0;
            st_err   <= 1'b0;
        end else begin
            st_valid <= accept;
            if (accept) begin
                st_tens <= dec_tens[3:0];
                st_ones <= dec_ones[3:0];
                st_err  <= dec_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_count <= '0;
        end else if (clr_err) begin
            err_count <= '0;
        end else if (accept && dec_err && (err_count != '1)) begin
            err_count <= err_count + ERR_W'(1);
        end
    end

endmodule
